// File: rtl/fxp_pkg.sv
// Shared defaults and sign-magnitude helpers for the fixed-point arithmetic unit.
// Imported by fxp_addsub_pipe and fxp_sm_core.
package fxp_pkg;

   localparam int unsigned FXP_INT_W  = 8;
   localparam int unsigned FXP_FRAC_W = 8;

   // Sign bit sits directly above the magnitude field.
   function automatic int unsigned sign_idx(input int unsigned mag_w);
      return mag_w;
   endfunction

   function automatic int unsigned mag_msb(input int unsigned mag_w);
      return mag_w - 1;
   endfunction

   // Largest representable magnitude, 2^mag_w - 1, zero-extended to 64 bits.
   function automatic logic [63:0] sat_max_mag(input int unsigned mag_w);
      return (64'd1 << mag_w) - 64'd1;
   endfunction

endpackage

// File: rtl/fxp_sm_core.sv
// Combinational sign-magnitude add/sub core: magnitude op, sign select, zero fix, overflow.
// Optional clamping on overflow when FXP_ADDSUB_SAT_EN is defined.
module fxp_sm_core
   import fxp_pkg::*;
#(
   parameter int unsigned MAG_W = 16
) (
   input  logic [MAG_W-1:0] m1,
   input  logic [MAG_W-1:0] m2,
   input  logic             sign1,
   input  logic             s2e,
   input  logic             eff_sub,
   input  logic             m1_ge_m2,
   output logic             sign,
   output logic [MAG_W:0]   mag,
   output logic             ovf
);

`ifdef FXP_ADDSUB_SAT_EN
   localparam logic [63:0] SAT_MAX64 = sat_max_mag(MAG_W);
   localparam logic [MAG_W:0] SAT_MAX = SAT_MAX64[MAG_W:0];
`endif

   logic [MAG_W:0] raw;

   always_comb begin
      raw  = '0;
      sign = 1'b0;
      if (!eff_sub) begin
         raw  = {1'b0, m1} + {1'b0, m2};
         sign = sign1;
      end else if (m1_ge_m2) begin
         raw  = {1'b0, m1 - m2};
         sign = sign1;
      end else begin
         raw  = {1'b0, m2 - m1};
         sign = s2e;
      end
      ovf = raw[MAG_W];
      // Never emit negative zero, including from -0 operands.
      if (raw == '0) sign = 1'b0;
`ifdef FXP_ADDSUB_SAT_EN
      mag = ovf ? SAT_MAX : raw;
`else
      mag = raw;
`endif
   end

endmodule

// File: rtl/fxp_addsub_pipe.sv
// Two-stage pipelined sign-magnitude fixed-point adder/subtractor with valid/ready on both
// sides and a saturating overflow counter. FXP_ADDSUB_SAT_EN enables result clamping.
module fxp_addsub_pipe
   import fxp_pkg::*;
#(
   parameter int unsigned INT_W  = FXP_INT_W,
   parameter int unsigned FRAC_W = FXP_FRAC_W,
   parameter int unsigned CNT_W  = 8,
   localparam int unsigned MAG_W = INT_W + FRAC_W,
   localparam int unsigned W     = MAG_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     operand1,
   input  logic [W-1:0]     operand2,
   input  logic             add_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       result,
   output logic             ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic             cnt_clr
);

   localparam int unsigned SIGN_IDX = sign_idx(MAG_W);
   localparam int unsigned MAG_MSB  = mag_msb(MAG_W);

   // Stage 1 state
   logic             s1_valid_q;
   logic [MAG_W-1:0] s1_m1_q, s1_m2_q;
   logic             s1_sign1_q, s1_s2e_q, s1_eff_sub_q, s1_ge_q;

   // Stage 2 / output state
   logic             out_valid_q;
   logic [W:0]       result_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic             s1_load, s2_load;
   logic [MAG_W-1:0] in_m1, in_m2;
   logic             in_s2e;
   logic             core_sign, core_ovf;
   logic [MAG_W:0]   core_mag;

   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   assign in_m1  = operand1[MAG_MSB:0];
   assign in_m2  = operand2[MAG_MSB:0];
   assign in_s2e = operand2[SIGN_IDX] ^ add_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_m1_q      <= '0;
         s1_m2_q      <= '0;
         s1_sign1_q   <= 1'b0;
         s1_s2e_q     <= 1'b0;
         s1_eff_sub_q <= 1'b0;
         s1_ge_q      <= 1'b0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_m1_q      <= in_m1;
            s1_m2_q      <= in_m2;
            s1_sign1_q   <= operand1[SIGN_IDX];
            s1_s2e_q     <= in_s2e;
            s1_eff_sub_q <= operand1[SIGN_IDX] ^ in_s2e;
            s1_ge_q      <= (in_m1 >= in_m2);
         end
      end
   end

   fxp_sm_core #(
      .MAG_W(MAG_W)
   ) u_core (
      .m1       (s1_m1_q),
      .m2       (s1_m2_q),
      .sign1    (s1_sign1_q),
      .s2e      (s1_s2e_q),
      .eff_sub  (s1_eff_sub_q),
      .m1_ge_m2 (s1_ge_q),
      .sign     (core_sign),
      .mag      (core_mag),
      .ovf      (core_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            result_q <= {core_sign, core_mag};
            ovf_q    <= core_ovf;
         end
      end
   end

   // Counts delivered overflows only; clear takes priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (out_valid_q && out_ready && ovf_q && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Directed self-checking bench for fxp_addsub_pipe in the default Q8.8 configuration.
module tb_fxp_addsub_pipe;

   localparam int unsigned MAG_W = 16;
   localparam int unsigned W     = MAG_W + 1;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     operand1;
   logic [W-1:0]     operand2;
   logic             add_sub;
   logic             out_valid;
   logic             out_ready;
   logic [W:0]       result;
   logic             ovf;
   logic [CNT_W-1:0] ovf_cnt;
   logic             cnt_clr;

   int total = 0;
   int bad   = 0;

`ifdef FXP_ADDSUB_SAT_EN
   localparam logic [W:0] OVF_RES  = 18'h0FFFF;
   localparam logic [W:0] OVF_RES2 = 18'h2FFFF;
`else
   localparam logic [W:0] OVF_RES  = 18'h10100;
   localparam logic [W:0] OVF_RES2 = 18'h3FFFE;
`endif

   fxp_addsub_pipe #(
      .INT_W  (8),
      .FRAC_W (8),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand1  (operand1),
      .operand2  (operand2),
      .add_sub   (add_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .ovf_cnt   (ovf_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation: checks acceptance, 2-cycle latency, result and ovf.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic as, input logic [W:0] exp_res, input logic exp_ovf);
      in_valid  = 1'b1;
      operand1  = a;
      operand2  = b;
      add_sub   = as;
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      #1;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_result"}, 32'(result), 32'(exp_res));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      step();
   endtask

   logic [W:0] exp_q[$];
   int         tx, rx;
   logic [W:0] exp_head;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      operand1  = '0;
      operand2  = '0;
      add_sub   = 1'b0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      run_op("add",      17'h00180, 17'h00240, 1'b0, 18'h003C0, 1'b0);
      run_op("mix_add",  17'h10180, 17'h00240, 1'b0, 18'h000C0, 1'b0);
      run_op("sub_neg",  17'h00180, 17'h00240, 1'b1, 18'h200C0, 1'b0);
      run_op("zero",     17'h10100, 17'h00100, 1'b0, 18'h00000, 1'b0);
      run_op("negzero",  17'h10000, 17'h00000, 1'b1, 18'h00000, 1'b0);
      run_op("sub_neg2", 17'h00300, 17'h10100, 1'b1, 18'h00400, 1'b0);
      run_op("ovf",      17'h0FF00, 17'h00200, 1'b0, OVF_RES, 1'b1);
      check("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
      run_op("ovf_neg",  17'h1FFFF, 17'h0FFFF, 1'b1, OVF_RES2, 1'b1);
      check("ovf_cnt_2", 32'(ovf_cnt), 32'd2);

      // 300 back-to-back overflows saturate the counter.
      in_valid  = 1'b1;
      operand1  = 17'h0FF00;
      operand2  = 17'h00200;
      add_sub   = 1'b0;
      out_ready = 1'b1;
      repeat (300) step();
      in_valid = 1'b0;
      repeat (3) step();
      check("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);

      // Clear coinciding with an overflow handshake must win.
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("clr_pre_valid", 32'(out_valid), 32'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
      step();

      // Backpressure: 5 ops, out_ready low for the first 4 cycles.
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = (cyc >= 4);
         in_valid  = (tx < 5);
         operand1  = 17'((tx + 1) * 256);
         operand2  = 17'h00001;
         add_sub   = 1'b0;
         #1;
         if (cyc == 2 || cyc == 3) begin
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_accepted", 32'(tx), 32'd2);
            check("bp_hold_result", 32'(result), 32'h00101);
         end
         if (out_valid && out_ready) begin
            exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("bp_result", 32'(result), 32'(exp_head));
            rx++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(18'((tx + 1) * 256 + 1));
            tx++;
         end
         step();
         if (rx == 5) break;
      end
      in_valid = 1'b0;
      check("bp_delivered", 32'(rx), 32'd5);
      step();
      check("bp_no_dup", 32'(out_valid), 32'd0);

      // Reset with both stages full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      operand1  = 17'h0FF00;
      operand2  = 17'h00200;
      step();
      step();
      check("rst_full_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_no_stale", 32'(out_valid), 32'd0);
      end
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
